// File: rtl/store_buffer_pkg.sv
// Shared types for the posted store buffer.
// Word, alignment-select and queue-entry definitions.
package store_buffer_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  ALR_t;

  typedef struct packed {
    logic [29:0] waddr;
    word_t       data;
    logic [3:0]  strb;
  } sbuf_entry_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_LR   = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

endpackage

// File: rtl/store_buffer_memoutput.sv
// Store data aligner: places register data on byte lanes
// and produces the matching byte strobes.
module memoutput
  import store_buffer_pkg::*;
(
  input  logic [1:0] i_off,
  input  word_t      i_data,
  input  logic [1:0] i_size,
  input  ALR_t       i_alr,
  output word_t      o_wdata,
  output logic [3:0] o_wstrb
);

  logic [63:0] w_dd;
  logic [63:0] w_rotl;
  logic [63:0] w_rotr;

  assign w_dd   = {i_data, i_data};
  assign w_rotl = w_dd << {i_off, 3'b000};
  // 3 - off equals ~off for a 2-bit offset
  assign w_rotr = w_dd >> {~i_off, 3'b000};

  always_comb begin
    o_wdata = i_data;
    o_wstrb = 4'b1111;
    unique case (i_size)
      SZ_BYTE: begin
        o_wdata = {4{i_data[7:0]}};
        o_wstrb = 4'b0001 << i_off;
      end
      SZ_HALF: begin
        o_wdata = {2{i_data[15:0]}};
        o_wstrb = i_off[1] ? 4'b1100 : 4'b0011;
      end
      SZ_LR: begin
        if (i_alr[0]) begin
          o_wdata = w_rotr[31:0];
          o_wstrb = 4'b1111 >> ~i_off;
        end else begin
          o_wdata = w_rotl[63:32];
          o_wstrb = 4'b1111 << i_off;
        end
      end
      SZ_WORD: begin
        o_wdata = i_data;
        o_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted store queue between MEM and the data-bus write port.
// In-order drain, same-word merge into the youngest idle entry.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [31:0]            st_addr,
  input  word_t                  st_data,
  input  logic [1:0]             st_size,
  input  ALR_t                   st_alr,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_addr,
  output logic                   ld_hit,
  output logic                   bus_req,
  output logic [31:0]            bus_addr,
  output word_t                  bus_wdata,
  output logic [3:0]             bus_wstrb,
  input  logic                   bus_ack,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sbuf_entry_t       r_q [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  word_t             w_wdata;
  logic [3:0]        w_wstrb;
  logic [PW-1:0]     w_young;
  logic              w_acc;
  logic              w_pop;
  logic              w_merge;
  logic              w_alloc;
  logic              w_hit;
  logic [PW-1:0]     w_off;
  sbuf_entry_t       w_head;
  logic              w_unused_ld;

  memoutput u_align (
    .i_off   (st_addr[1:0]),
    .i_data  (st_data),
    .i_size  (st_size),
    .i_alr   (st_alr),
    .o_wdata (w_wdata),
    .o_wstrb (w_wstrb)
  );

  assign w_unused_ld = ^ld_addr[1:0];

  assign st_ready = r_count < CW'(DEPTH);
  assign bus_req  = r_count != '0;
  assign empty    = r_count == '0;
  assign count    = r_count;

  assign w_acc   = st_valid && st_ready;
  assign w_pop   = bus_req && bus_ack;
  assign w_young = r_tail - PW'(1);

  // With count==2 a pop promotes the youngest to head, so no merge.
  assign w_merge = w_acc
                && (r_count >= CW'(2))
                && (r_q[w_young].waddr == st_addr[31:2])
                && !(w_pop && r_count == CW'(2));
  assign w_alloc = w_acc && !w_merge;

  assign w_head    = r_q[r_head];
  assign bus_addr  = bus_req ? {w_head.waddr, 2'b00} : '0;
  assign bus_wdata = bus_req ? w_head.data : '0;
  assign bus_wstrb = bus_req ? w_head.strb : '0;

  always_comb begin
    w_hit = 1'b0;
    w_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_head;
      if (({1'b0, w_off} < r_count)
          && (r_q[i].waddr == ld_addr[31:2]))
        w_hit = 1'b1;
    end
    ld_hit = ld_valid && w_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_q[i] <= '0;
    end else begin
      if (w_merge) begin
        for (int b = 0; b < 4; b++)
          if (w_wstrb[b])
            r_q[w_young].data[8*b +: 8] <= w_wdata[8*b +: 8];
        r_q[w_young].strb <= r_q[w_young].strb | w_wstrb;
      end else if (w_alloc) begin
        r_q[r_tail].waddr <= st_addr[31:2];
        r_q[r_tail].data  <= w_wdata;
        r_q[r_tail].strb  <= w_wstrb;
        r_tail            <= r_tail + PW'(1);
      end
      if (w_pop)
        r_head <= r_head + PW'(1);
      unique case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
